// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: a word loaded via valid/ready handshake
// is shifted out one bit per clk edge, with seamless back-to-back frames and a shift_en stall.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_shifted;

  assign sreg_shifted = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, sreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last bit of a frame may hand straight over to the next word when
  // load_valid is present, which is what keeps back-to-back frames gap-free.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          sreg_d  = din;
          cnt_d   = LAST_CNT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q != '0) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q - CW'(1);
          end else if (load_valid) begin
            sreg_d = din;
            cnt_d  = LAST_CNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sout_valid  = (state_q == SHIFT);
  assign sout        = sout_valid ? ((MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0]) : 1'b0;
  assign frame_start = sout_valid && (cnt_q == LAST_CNT);
  assign done        = sout_valid && (cnt_q == '0);
  assign load_ready  = (state_q == IDLE) || (sout_valid && (cnt_q == '0) && shift_en);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: constant vector tables, directed corner
// sequences and random traffic against a bit-queue reference model.
module tb_piso_shift_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic readyM, soutM, validM, fsM, doneM;
  logic readyL, soutL, validL, fsL, doneL;

  int passed = 0;
  int total  = 0;

  // Reference: pending bits of the word on the wire, in transmit order.
  bit qm[$];
  bit ql[$];

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .clr(clr), .din(din), .load_valid(load_valid),
    .load_ready(readyM), .shift_en(shift_en), .sout(soutM),
    .sout_valid(validM), .frame_start(fsM), .done(doneM)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .clr(clr), .din(din), .load_valid(load_valid),
    .load_ready(readyL), .shift_en(shift_en), .sout(soutL),
    .sout_valid(validL), .frame_start(fsL), .done(doneL)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         lv;
    logic         se;
    logic [W-1:0] d;
    logic         expSoutM;
    logic         expSoutL;
    logic         expValid;
    logic         expFs;
    logic         expDone;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelClear();
    qm.delete();
    ql.delete();
  endtask

  task automatic modelPush(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " soutM"},  soutM,  (qm.size() > 0) ? qm[0] : 1'b0);
    checkOutput({tag, " soutL"},  soutL,  (ql.size() > 0) ? ql[0] : 1'b0);
    checkOutput({tag, " valid"},  {validM, validL}, {2{qm.size() > 0}});
    checkOutput({tag, " fstart"}, {fsM, fsL},       {2{qm.size() == W}});
    checkOutput({tag, " done"},   {doneM, doneL},   {2{qm.size() == 1}});
  endtask

  // One clock cycle of traffic: drive inputs, check ready, advance DUT and model together.
  task automatic applyStimulus(input logic lv, input logic se, input logic [W-1:0] d, input string tag);
    bit expReady;
    load_valid = lv;
    shift_en   = se;
    din        = d;
    #1;
    expReady = (qm.size() == 0) || (qm.size() == 1 && se);
    checkOutput({tag, " ready"}, {readyM, readyL}, {2{expReady}});
    tick();
    if (qm.size() == 0) begin
      if (lv) modelPush(d);
    end else if (se) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      if (qm.size() == 0 && lv) modelPush(d);
    end
    checkModel(tag);
  endtask

  function automatic vec_t mkVec(logic lv, logic se, logic [W-1:0] d,
                                 logic sm, logic sl, logic v, logic fs, logic dn);
    vec_t r;
    r.lv = lv; r.se = se; r.d = d;
    r.expSoutM = sm; r.expSoutL = sl; r.expValid = v; r.expFs = fs; r.expDone = dn;
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single A5 frame, then A5/3C back to back. Both words read the same MSB- or LSB-first.
    vecs.push_back(mkVec(1, 1, 8'hA5, 1, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 1));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 1, 8'hA5, 1, 1, 1, 1, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 1));
    vecs.push_back(mkVec(1, 1, 8'h3C, 0, 0, 1, 1, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 0, 0, 0));

    // Reset and idle state
    repeat (2) tick();
    clr = 1'b0;
    tick();
    checkOutput("reset ready", {readyM, readyL}, 2'b11);
    checkOutput("reset valid", {validM, validL}, 2'b00);
    checkOutput("reset sout",  {soutM, soutL},   2'b00);
    checkOutput("reset flags", {fsM, doneM, fsL, doneL}, 4'b0000);

    // Constant vector table
    for (int i = 0; i < vecs.size(); i++) begin
      load_valid = vecs[i].lv;
      shift_en   = vecs[i].se;
      din        = vecs[i].d;
      tick();
      checkOutput($sformatf("vec%0d soutM", i), soutM, vecs[i].expSoutM);
      checkOutput($sformatf("vec%0d soutL", i), soutL, vecs[i].expSoutL);
      checkOutput($sformatf("vec%0d valid", i), {validM, validL}, {2{vecs[i].expValid}});
      checkOutput($sformatf("vec%0d fs/done", i), {fsM, doneM}, {vecs[i].expFs, vecs[i].expDone});
    end
    modelClear();

    // LSB-first 8'h01 with a three-cycle stall after bit 2
    applyStimulus(1, 1, 8'h01, "stall b1");
    checkOutput("stall b1 soutL", soutL, 1'b1);
    applyStimulus(0, 1, 8'h00, "stall b2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 8'hFF, "stall hold");
      checkOutput("stall hold soutL", {soutL, validL, doneL}, 3'b010);
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 8'h00, "stall tail");
    checkOutput("stall last done", {doneL, soutM}, 2'b11);
    applyStimulus(0, 1, 8'h00, "stall idle");
    checkOutput("stall idle valid", validL, 1'b0);

    // Asynchronous clear during bit 4 of 8'hFF, then an intact word
    applyStimulus(1, 1, 8'hFF, "clr b1");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h00, "clr bits");
    #3 clr = 1'b1;
    #1;
    checkOutput("clr async sout",  {soutM, soutL},   2'b00);
    checkOutput("clr async valid", {validM, validL}, 2'b00);
    checkOutput("clr async ready", {readyM, readyL}, 2'b11);
    modelClear();
    tick();
    clr = 1'b0;
    applyStimulus(0, 1, 8'h00, "clr idle");
    applyStimulus(1, 1, 8'h96, "post clr b1");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'h00, "post clr");
    checkOutput("post clr idle", validM, 1'b0);

    // load_valid pulses with 8'h00 mid-frame must be ignored
    applyStimulus(1, 1, 8'hC3, "ign b1");
    for (int i = 2; i <= 7; i++) applyStimulus(1, 1, 8'h00, "ign pulse");
    checkOutput("ign bit7 soutM", soutM, 1'b1);
    applyStimulus(0, 1, 8'h00, "ign b8");
    checkOutput("ign done", {doneM, soutM, soutL}, 3'b111);
    applyStimulus(0, 1, 8'h00, "ign idle");
    checkOutput("ign idle valid", {validM, validL}, 2'b00);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 3) != 0, ($urandom % 4) != 0, W'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
